// File: rtl/multicycle_control.sv
// multicycle_control -- main control FSM for a multicycle MIPS-style datapath.
//
// Sequences FETCH / DECODE / execute / writeback for R-type ALU ops, addi,
// lw, sw, beq and j. Memory states (FETCH, MEM_RD, MEM_WR) stretch over
// MEM_WAIT+1 cycles using a down-counter. The final-cycle enables (PCWrite,
// IRWrite, MDRWrite) fire only in the last cycle of a memory state.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-low
//   Opcode       IR[31:26], valid from DECODE onward
//   Funct        IR[5:0]
//   Zero         ALU zero flag, used only in BRANCH
//   PCWrite, IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite
//                register load enables
//   MemRead, MemWrite  memory strobes
//   IorD         memory address select (0 = PC, 1 = ALUOut)
//   RegDst       write register select (0 = rt, 1 = rd)
//   MemToReg     write data select (0 = ALUOut, 1 = MDR)
//   AluSrcA      0 = PC, 1 = B, 2 = A, 3 = MDR
//   AluSrcB      0 = B, 1 = 4, 2 = sext(imm), 3 = sext(imm)<<2
//   AluOp        000 = pass A, 001 = add, 010 = sub, 011 = and
//   PCSource     0 = ALU result, 1 = ALUOut, 2 = jump target
//   IllegalOp    one-cycle pulse in DECODE for an undecoded instruction
//   State        current state code (debug)
module multicycle_control #(
  parameter int unsigned MEM_WAIT = 1  // legal range 0..15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic       PCWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       RegWrite,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IorD,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [1:0] AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluOp,
  output logic [1:0] PCSource,
  output logic       IllegalOp,
  output logic [3:0] State
);

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC_R   = 4'd3,
    S_WB_R     = 4'd4,
    S_EXEC_I   = 4'd5,
    S_WB_I     = 4'd6,
    S_MEM_ADDR = 4'd7,
    S_MEM_RD   = 4'd8,
    S_MEM_WB   = 4'd9,
    S_MEM_WR   = 4'd10,
    S_BRANCH   = 4'd11,
    S_JUMP     = 4'd12
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;

  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_SUB = 3'b010;
  localparam logic [2:0] ALU_AND = 3'b011;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_e     state_q, state_d;
  logic [3:0] wait_q, wait_d;
  logic       last_cyc;
  logic       rtype_ok;

  // A memory state's last cycle is the one in which the counter has run out.
  assign last_cyc = (wait_q == 4'd0);
  assign rtype_ok = (Funct == FN_ADD) || (Funct == FN_SUB) || (Funct == FN_AND);
  assign State    = state_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
      wait_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    PCWrite     = 1'b0;
    IRWrite     = 1'b0;
    MDRWrite    = 1'b0;
    ABWrite     = 1'b0;
    ALUOutWrite = 1'b0;
    RegWrite    = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IorD        = 1'b0;
    RegDst      = 1'b0;
    MemToReg    = 1'b0;
    AluSrcA     = 2'd0;
    AluSrcB     = 2'd0;
    AluOp       = 3'b000;
    PCSource    = 2'd0;
    IllegalOp   = 1'b0;

    unique case (state_q)
      S_RESET: state_d = S_FETCH;

      S_FETCH: begin
        MemRead = 1'b1;
        AluSrcB = 2'd1;
        AluOp   = ALU_ADD;
        if (last_cyc) begin
          PCWrite = 1'b1;
          IRWrite = 1'b1;
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        // Register read and branch-target precompute happen for every
        // instruction, legal or not.
        ABWrite     = 1'b1;
        ALUOutWrite = 1'b1;
        AluSrcB     = 2'd3;
        AluOp       = ALU_ADD;
        if (Opcode == OP_RTYPE && rtype_ok)        state_d = S_EXEC_R;
        else if (Opcode == OP_ADDI)                state_d = S_EXEC_I;
        else if (Opcode == OP_LW || Opcode == OP_SW) state_d = S_MEM_ADDR;
        else if (Opcode == OP_BEQ)                 state_d = S_BRANCH;
        else if (Opcode == OP_J)                   state_d = S_JUMP;
        else begin
          IllegalOp = 1'b1;
          state_d   = S_FETCH;
        end
      end

      S_EXEC_R: begin
        AluSrcA     = 2'd2;
        ALUOutWrite = 1'b1;
        case (Funct)
          FN_ADD:  AluOp = ALU_ADD;
          FN_SUB:  AluOp = ALU_SUB;
          FN_AND:  AluOp = ALU_AND;
          default: AluOp = 3'b000;
        endcase
        state_d = S_WB_R;
      end

      S_WB_R: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        state_d  = S_FETCH;
      end

      S_EXEC_I: begin
        AluSrcA     = 2'd2;
        AluSrcB     = 2'd2;
        AluOp       = ALU_ADD;
        ALUOutWrite = 1'b1;
        state_d     = S_WB_I;
      end

      S_WB_I: begin
        RegWrite = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_ADDR: begin
        AluSrcA     = 2'd2;
        AluSrcB     = 2'd2;
        AluOp       = ALU_ADD;
        ALUOutWrite = 1'b1;
        // Opcode is re-examined here; if it no longer names a load or
        // store, abandon the instruction rather than guess.
        if (Opcode == OP_LW)      state_d = S_MEM_RD;
        else if (Opcode == OP_SW) state_d = S_MEM_WR;
        else                      state_d = S_FETCH;
      end

      S_MEM_RD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (last_cyc) begin
          MDRWrite = 1'b1;
          state_d  = S_MEM_WB;
        end
      end

      S_MEM_WB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = S_FETCH;
      end

      S_MEM_WR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (last_cyc) state_d = S_FETCH;
      end

      S_BRANCH: begin
        AluSrcA  = 2'd2;
        AluOp    = ALU_SUB;
        PCSource = 2'd1;
        PCWrite  = Zero;
        state_d  = S_FETCH;
      end

      S_JUMP: begin
        PCSource = 2'd2;
        PCWrite  = 1'b1;
        state_d  = S_FETCH;
      end

      // Unused codes 13-15 recover through RESET.
      default: state_d = S_RESET;
    endcase

    // Wait counter: reload on any transition into a memory state, count
    // down while a memory state holds. Only memory states ever self-loop.
    wait_d = wait_q;
    if (state_d != state_q) begin
      if (state_d == S_FETCH || state_d == S_MEM_RD || state_d == S_MEM_WR)
        wait_d = WAIT_INIT;
      else
        wait_d = 4'd0;
    end else if (!last_cyc) begin
      wait_d = wait_q - 4'd1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: three instances with MEM_WAIT = 0, 1, 2 run
// in lockstep. An instruction-level model expands each instruction into its
// expected per-cycle state/output trace; one compare process checks every
// cycle. Tagged instructions keep their observed traces for literal checks.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, mdrw, abw, aluow, regw, memr, memw, iord, regdst, m2r;
    logic [1:0] srca, srcb;
    logic [2:0] aluop;
    logic [1:0] pcsrc;
    logic ill;
  } obs_t;

  typedef struct {
    logic [5:0] op, fn;
    logic       z;
    obs_t       exp;
    int         tag;
  } item_t;

  localparam int K_R = 0, K_I = 1, K_LW = 2, K_SW = 3, K_BEQ = 4, K_J = 5, K_ILL = 6;

  logic       clk = 1'b0;
  logic       rst_n [3];
  logic [5:0] op    [3];
  logic [5:0] fn    [3];
  logic       zr    [3];
  obs_t       act   [3];

  item_t stim [3][$];
  item_t expq [3][$];
  obs_t  trace [16][$];

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic pcw, irw, mdrw, abw, aluow, regw, memr, memw, iord, regdst, m2r, il;
    logic [1:0] sa, sb, ps;
    logic [2:0] ao;
    logic [3:0] st;
    multicycle_control #(.MEM_WAIT(g)) u_dut (
      .clk(clk), .reset(rst_n[g]), .Opcode(op[g]), .Funct(fn[g]), .Zero(zr[g]),
      .PCWrite(pcw), .IRWrite(irw), .MDRWrite(mdrw), .ABWrite(abw),
      .ALUOutWrite(aluow), .RegWrite(regw), .MemRead(memr), .MemWrite(memw),
      .IorD(iord), .RegDst(regdst), .MemToReg(m2r), .AluSrcA(sa), .AluSrcB(sb),
      .AluOp(ao), .PCSource(ps), .IllegalOp(il), .State(st)
    );
    assign act[g] = {st, pcw, irw, mdrw, abw, aluow, regw, memr, memw, iord,
                     regdst, m2r, sa, sb, ao, ps, il};
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
  endtask

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic int classify(input logic [5:0] o, input logic [5:0] f);
    if (o == 6'h00 && (f == 6'h20 || f == 6'h22 || f == 6'h24)) return K_R;
    if (o == 6'h08) return K_I;
    if (o == 6'h23) return K_LW;
    if (o == 6'h2B) return K_SW;
    if (o == 6'h04) return K_BEQ;
    if (o == 6'h02) return K_J;
    return K_ILL;
  endfunction

  task automatic push(input int g, input logic [5:0] o, input logic [5:0] f,
                      input logic z, input obs_t e, input int tag);
    item_t it;
    it.op = o; it.fn = f; it.z = z; it.exp = e; it.tag = tag;
    stim[g].push_back(it);
  endtask

  // Expand one instruction into its cycle-by-cycle expectation. Inputs the
  // FSM must ignore in a given cycle are driven with random garbage.
  task automatic gen(input int g, input logic [5:0] o, input logic [5:0] f,
                     input logic z, input int tag);
    obs_t e;
    int   kind;
    for (int k = 0; k <= g; k++) begin
      e = '0; e.st = 4'd1; e.memr = 1; e.srcb = 2'd1; e.aluop = 3'd1;
      if (k == g) begin e.pcw = 1; e.irw = 1; end
      push(g, r6(), r6(), r1(), e, tag);
    end
    kind = classify(o, f);
    e = '0; e.st = 4'd2; e.abw = 1; e.aluow = 1; e.srcb = 2'd3; e.aluop = 3'd1;
    e.ill = (kind == K_ILL);
    push(g, o, f, r1(), e, tag);
    case (kind)
      K_R: begin
        e = '0; e.st = 4'd3; e.srca = 2'd2; e.aluow = 1;
        e.aluop = (f == 6'h20) ? 3'd1 : (f == 6'h22) ? 3'd2 : 3'd3;
        push(g, o, f, r1(), e, tag);
        e = '0; e.st = 4'd4; e.regw = 1; e.regdst = 1;
        push(g, r6(), r6(), r1(), e, tag);
      end
      K_I: begin
        e = '0; e.st = 4'd5; e.srca = 2'd2; e.srcb = 2'd2; e.aluop = 3'd1; e.aluow = 1;
        push(g, r6(), r6(), r1(), e, tag);
        e = '0; e.st = 4'd6; e.regw = 1;
        push(g, r6(), r6(), r1(), e, tag);
      end
      K_LW, K_SW: begin
        e = '0; e.st = 4'd7; e.srca = 2'd2; e.srcb = 2'd2; e.aluop = 3'd1; e.aluow = 1;
        push(g, o, r6(), r1(), e, tag);
        for (int k = 0; k <= g; k++) begin
          e = '0; e.iord = 1;
          if (kind == K_LW) begin e.st = 4'd8; e.memr = 1; e.mdrw = (k == g); end
          else begin e.st = 4'd10; e.memw = 1; end
          push(g, r6(), r6(), r1(), e, tag);
        end
        if (kind == K_LW) begin
          e = '0; e.st = 4'd9; e.regw = 1; e.m2r = 1;
          push(g, r6(), r6(), r1(), e, tag);
        end
      end
      K_BEQ: begin
        e = '0; e.st = 4'd11; e.srca = 2'd2; e.aluop = 3'd2; e.pcsrc = 2'd1; e.pcw = z;
        push(g, r6(), r6(), z, e, tag);
      end
      K_J: begin
        e = '0; e.st = 4'd12; e.pcsrc = 2'd2; e.pcw = 1;
        push(g, r6(), r6(), r1(), e, tag);
      end
      default: ;
    endcase
  endtask

  task automatic gen_random(input int g);
    logic [5:0] o, f;
    o = 6'h00; f = r6();
    case ($urandom_range(0, 11))
      0: f = 6'h20;
      1: f = 6'h22;
      2: f = 6'h24;
      3: f = 6'h21;
      4: o = 6'h08;
      5: o = 6'h23;
      6: o = 6'h2B;
      7: o = 6'h04;
      8: o = 6'h02;
      9: o = 6'h3F;
      10: o = r6();
      default: ;
    endcase
    gen(g, o, f, r1(), 0);
  endtask

  task automatic step();
    item_t it;
    @(posedge clk); #1;
    for (int g = 0; g < 3; g++) begin
      if (stim[g].size() == 0) gen_random(g);
      it = stim[g].pop_front();
      op[g] = it.op; fn[g] = it.fn; zr[g] = it.z;
      expq[g].push_back(it);
    end
  endtask

  // Single compare process: every cycle with an outstanding expectation.
  always @(negedge clk) begin : cmp
    item_t it;
    for (int g = 0; g < 3; g++) begin
      if (expq[g].size() > 0) begin
        it = expq[g].pop_front();
        chk($sformatf("model_mw%0d", g), 64'(act[g]), 64'(it.exp));
        if (it.tag != 0) trace[it.tag].push_back(act[g]);
      end
    end
  end

  initial begin : main
    obs_t       e;
    logic [35:0] sv;
    logic [8:0]  irw_v, mdrw_v;
    logic [23:0] sw_seq;
    int          cnt, rw;

    for (int g = 0; g < 3; g++) begin
      rst_n[g] = 1'b1; op[g] = '0; fn[g] = '0; zr[g] = 1'b0;
    end
    #1;
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) chk("reset_async", 64'(act[g]), 64'd0);
    @(posedge clk); @(posedge clk); #3;
    for (int g = 0; g < 3; g++) chk("reset_held", 64'(act[g]), 64'd0);
    @(negedge clk);
    for (int g = 0; g < 3; g++) rst_n[g] = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) chk("release_state", 64'(act[g].st), 64'd0);

    // Directed instructions, tagged for literal checks.
    gen(0, 6'h00, 6'h20, 1'b0, 1);  // add
    gen(0, 6'h3F, 6'h00, 1'b0, 2);  // illegal opcode
    gen(0, 6'h00, 6'h21, 1'b0, 3);  // illegal funct
    gen(2, 6'h23, 6'h00, 1'b0, 4);  // lw, MEM_WAIT=2
    gen(1, 6'h04, 6'h00, 1'b0, 5);  // beq not taken
    gen(1, 6'h04, 6'h00, 1'b1, 6);  // beq taken
    gen(1, 6'h2B, 6'h00, 1'b0, 7);  // sw, MEM_WAIT=1
    gen(1, 6'h02, 6'h00, 1'b0, 8);  // j

    repeat (1500) step();
    @(negedge clk); #1;

    // Reset in the middle of a store on the MEM_WAIT=1 instance.
    rst_n[1] = 1'b0;
    @(negedge clk);
    rst_n[1] = 1'b1; op[1] = 6'h2B; fn[1] = 6'h00; zr[1] = 1'b0;
    #1;
    chk("sw_release_state", 64'(act[1].st), 64'd0);
    sw_seq = 24'h1127AA;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk($sformatf("sw_state%0d", k), 64'(act[1].st), 64'(sw_seq[23-4*k -: 4]));
      chk($sformatf("sw_memw%0d", k), 64'(act[1].memw), 64'(k >= 4));
    end
    #2 rst_n[1] = 1'b0;
    #1;
    chk("midwr_reset_memw", 64'(act[1].memw), 64'd0);
    chk("midwr_reset_all", 64'(act[1]), 64'd0);
    @(posedge clk); #1;
    chk("midwr_reset_held", 64'(act[1]), 64'd0);
    @(negedge clk);
    rst_n[1] = 1'b1;
    #1;
    chk("midwr_release_state", 64'(act[1].st), 64'd0);
    @(posedge clk); #1;
    e = '0; e.st = 4'd1; e.memr = 1; e.srcb = 2'd1; e.aluop = 3'd1;
    chk("midwr_refetch", 64'(act[1]), 64'(e));

    // add with MEM_WAIT=0: states 1,2,3,4 then 1.
    chk("add_len", 64'(trace[1].size()), 64'd4);
    sv = '0; rw = 0;
    foreach (trace[1][i]) begin
      sv = {sv[31:0], trace[1][i].st};
      rw = (rw << 1) | int'(trace[1][i].regw && trace[1][i].regdst);
    end
    chk("add_states", 64'(sv), 64'h1234);
    chk("add_regw", 64'(rw), 64'b0001);
    if (trace[1].size() == 4) chk("add_aluop", 64'(trace[1][2].aluop), 64'd1);
    if (trace[2].size() > 0) chk("add_next_fetch", 64'(trace[2][0].st), 64'd1);

    // Illegal instructions: IllegalOp in DECODE, no other write enables.
    for (int t = 2; t <= 3; t++) begin
      chk($sformatf("ill%0d_len", t), 64'(trace[t].size()), 64'd2);
      if (trace[t].size() == 2) begin
        chk($sformatf("ill%0d_state", t), 64'(trace[t][1].st), 64'd2);
        chk($sformatf("ill%0d_pulse", t), 64'(trace[t][1].ill), 64'd1);
        chk($sformatf("ill%0d_wren", t),
            64'({trace[t][1].pcw, trace[t][1].regw, trace[t][1].memw}), 64'd0);
      end
    end
    if (trace[3].size() > 0) chk("ill_next_fetch", 64'(trace[3][0].st), 64'd1);

    // lw with MEM_WAIT=2.
    chk("lw_len", 64'(trace[4].size()), 64'd9);
    sv = '0; irw_v = '0; mdrw_v = '0;
    foreach (trace[4][i]) begin
      sv = {sv[31:0], trace[4][i].st};
      irw_v = {irw_v[7:0], trace[4][i].irw};
      mdrw_v = {mdrw_v[7:0], trace[4][i].mdrw};
    end
    chk("lw_states", 64'(sv), 64'h111278889);
    chk("lw_irw", 64'(irw_v), 64'b001000000);
    chk("lw_mdrw", 64'(mdrw_v), 64'b000000010);

    // beq not taken / taken.
    chk("beq0_len", 64'(trace[5].size()), 64'd4);
    if (trace[5].size() == 4)
      chk("beq0_pcw", 64'({trace[5][3].st, trace[5][3].pcw}), 64'({4'd11, 1'b0}));
    cnt = 0;
    foreach (trace[6][i]) if (trace[6][i].pcw && trace[6][i].pcsrc == 2'd1) cnt++;
    chk("beq1_taken_cycles", 64'(cnt), 64'd1);

    // sw with MEM_WAIT=1.
    chk("sw_len", 64'(trace[7].size()), 64'd6);
    cnt = 0; rw = 0;
    foreach (trace[7][i]) begin
      if (trace[7][i].memw && trace[7][i].iord) cnt++;
      if (trace[7][i].regw) rw++;
    end
    chk("sw_memw_cycles", 64'(cnt), 64'd2);
    chk("sw_regw", 64'(rw), 64'd0);
    if (trace[8].size() > 0) chk("sw_next_fetch", 64'(trace[8][0].st), 64'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 Parameter MEM_WAIT, default 1, memory wait cycles per access; the legal range SHALL be 0..15.
REQ-002 clk  input  1  the single clock; every state and counter update SHALL occur on its rising edge.
REQ-003 reset  input  1  SHALL be asynchronous and active-low.
REQ-004 Opcode  input  6  SHALL be IR[31:26], valid from DECODE onward.
REQ-005 Funct  input  6  SHALL be IR[5:0].
REQ-006 Zero  input  1  SHALL be the ALU zero flag.
REQ-007 PCWrite, IRWrite, MDRWrite, ABWrite, ALUOutWrite, RegWrite  output  1 each  SHALL be register load enables.
REQ-008 MemRead, MemWrite  output  1 each  SHALL be memory strobes.
REQ-009 IorD  output  1  SHALL select the memory address: 0 = PC, 1 = ALUOut.
REQ-010 RegDst, MemToReg  output  1 each  SHALL select the write register (0 = rt, 1 = rd) and the write data (0 = ALUOut, 1 = MDR).
REQ-011 AluSrcA  output  2  SHALL encode 0 = PC, 1 = B, 2 = A, 3 = MDR.
REQ-012 AluSrcB  output  2  SHALL encode 0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
REQ-013 AluOp  output  3  SHALL encode 000 = pass A, 001 = add, 010 = sub, 011 = and.
REQ-014 PCSource  output  2  SHALL encode 0 = ALU result, 1 = ALUOut, 2 = jump target.
REQ-015 IllegalOp  output  1  SHALL be the undecoded-instruction pulse.
REQ-016 State  output  4  SHALL be the current state code, for debug.

Function
REQ-017 Outputs SHALL be Moore-decoded from State, with WaitCnt used only where stated and Zero used only in BRANCH; any output not listed for a state SHALL be 0.
REQ-018 State codes SHALL be: RESET = 0, FETCH = 1, DECODE = 2, EXEC_R = 3, WB_R = 4, EXEC_I = 5, WB_I = 6, MEM_ADDR = 7, MEM_RD = 8, MEM_WB = 9, MEM_WR = 10, BRANCH = 11, JUMP = 12; codes 13-15 SHALL go to RESET on the next edge.
REQ-019 Memory states (FETCH, MEM_RD, MEM_WR) SHALL each last exactly MEM_WAIT+1 cycles, timed as follows:
- a 4-bit WaitCnt loads MEM_WAIT on entry;
- WaitCnt decrements each cycle;
- the state exits in the cycle WaitCnt = 0.
REQ-020 RESET SHALL drive all outputs 0 and go to FETCH on the first edge after reset deasserts.
REQ-021 FETCH SHALL drive MemRead = 1, IorD = 0, AluSrcA = 0, AluSrcB = 1, AluOp = 001 for all of its cycles; PCWrite = 1, PCSource = 0 and IRWrite = 1 SHALL be asserted only in its final cycle; it SHALL then go to DECODE.
REQ-022 DECODE SHALL last 1 cycle and drive ABWrite = 1, ALUOutWrite = 1, AluSrcA = 0, AluSrcB = 3, AluOp = 001.
REQ-023 DECODE SHALL dispatch on Opcode as follows:
- 0x00 with Funct 0x20/0x22/0x24 -> EXEC_R;
- 0x08 -> EXEC_I;
- 0x23 or 0x2B -> MEM_ADDR;
- 0x04 -> BRANCH;
- 0x02 -> JUMP;
- anything else -> FETCH with IllegalOp = 1 for that cycle, and no write enables other than ABWrite and ALUOutWrite.
REQ-024 EXEC_R SHALL drive AluSrcA = 2, AluSrcB = 0, ALUOutWrite = 1, and AluOp = 001/010/011 for Funct 0x20/0x22/0x24, then go to WB_R.
REQ-025 WB_R SHALL drive RegWrite = 1, RegDst = 1, MemToReg = 0, then go to FETCH.
REQ-026 EXEC_I SHALL drive AluSrcA = 2, AluSrcB = 2, AluOp = 001, ALUOutWrite = 1, then go to WB_I.
REQ-027 WB_I SHALL drive RegWrite = 1, RegDst = 0, MemToReg = 0, then go to FETCH.
REQ-028 MEM_ADDR SHALL drive the same ALU controls as EXEC_I, then go to MEM_RD when Opcode = 0x23 or to MEM_WR when Opcode = 0x2B.
REQ-029 MEM_RD SHALL drive MemRead = 1 and IorD = 1 for all of its cycles, with MDRWrite = 1 only in its final cycle, then go to MEM_WB.
REQ-030 MEM_WB SHALL drive RegWrite = 1, RegDst = 0, MemToReg = 1, then go to FETCH.
REQ-031 MEM_WR SHALL drive MemWrite = 1 and IorD = 1 for all of its cycles, then go to FETCH.
REQ-032 BRANCH SHALL drive AluSrcA = 2, AluSrcB = 0, AluOp = 010, PCSource = 1, ALUOutWrite = 0, and PCWrite = Zero sampled in that cycle, then go to FETCH.
REQ-033 JUMP SHALL drive PCSource = 2 and PCWrite = 1, then go to FETCH.
REQ-034 Opcode and Funct changes outside DECODE, MEM_ADDR and EXEC_R SHALL have no effect.

Reset
REQ-035 While reset = 0, State SHALL be RESET, WaitCnt SHALL be 0, and all outputs SHALL be 0, asynchronously and regardless of clk.
REQ-036 Reset asserted mid-access SHALL drop MemRead and MemWrite in the same cycle, with no partial write-enable pulse after release.

Verification
REQ-037 MEM_WAIT = 0, add (Opcode 0x00, Funct 0x20) -> States 1, 2, 3, 4, 1; AluOp = 001 in EXEC_R; RegWrite = 1 and RegDst = 1 only in WB_R.
REQ-038 MEM_WAIT = 2, lw (0x23) -> FETCH 3 cycles with IRWrite only in the 3rd, then DECODE, MEM_ADDR, MEM_RD 3 cycles with MDRWrite only in the 3rd, then MEM_WB (9 cycles total).
REQ-039 beq (0x04) with Zero = 0 -> PCWrite = 0 in BRANCH; with Zero = 1 -> PCWrite = 1 and PCSource = 1 for exactly 1 cycle.
REQ-040 Opcode 0x3F, or Opcode 0x00 with Funct 0x21 -> IllegalOp = 1 for 1 cycle in DECODE, next State = FETCH, and RegWrite, MemWrite and PCWrite never asserted.
REQ-041 MEM_WAIT = 1, sw (0x2B) -> MemWrite = 1 and IorD = 1 for exactly 2 cycles, RegWrite = 0 throughout, return to FETCH.
REQ-042 Reset dropped in the 2nd cycle of MEM_WR -> MemWrite = 0 immediately, State = 0; after release, State = 1 on the next edge.
